unsigned_divider_ctrl: RTL
==========================

# unsigned_divider_ctrl

Sequential controller for the 32-bit unsigned restoring divider. On each RUN cycle it steps the shift-in-next-dividend-bit remainder update (the `remainder_calculator` datapath), then performs the trial subtract and sets the quotient bit. It owns the iteration counter `i`, operand capture, the start/done handshake and the divide-by-zero shortcut. It sits between the core's request logic and the division datapath.

## Interface
- `WIDTH`, 32, operand width. Fixed at 32; `i` is 5 bits.
- `clk`  in  1  sole clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request. Accepted only on an edge where `ready`=1.
- `N`  in  32  dividend, sampled on the accepting edge.
- `D`  in  32  divisor, sampled on the accepting edge.
- `ready`  out  1  high in IDLE and DONE.
- `done`  out  1  one-cycle pulse; `Q` and `R` are valid from this cycle on.
- `Q`  out  32  quotient, registered.
- `R`  out  32  remainder, registered.
- `div_by_zero`  out  1  set with `done` when the latched `D`=0; held until the next accepted start.

## Operation
- States: IDLE, RUN, DONE.
- Reset (async, `rst_n`=0): state=IDLE, `i`=0, working regs=0, `Q`=0, `R`=0, `done`=0, `div_by_zero`=0, `ready`=1.
- **IDLE/DONE with `start`=1:**
  - Latch `N` and `D`.
  - Clear working remainder `Rw` and working quotient `Qw`.
  - Set `i`=0 and clear `div_by_zero`.
  - If `D`=0, go to DONE next with `Q`=32'hFFFFFFFF, `R`=`N`, `div_by_zero`=1. No RUN cycles occur.
  - Otherwise go to RUN.
- **DONE without `start`:** go to IDLE. `Q`, `R` and `div_by_zero` hold.
- **RUN, one iteration per edge:**
  - Shifted remainder: `S` = {`Rw`[31:0], `N`[31-i]}, 33 bits wide.
  - If `S` ≥ {1'b0,`D`}: `Rw` = (`S` − `D`)[31:0] and `Qw`[31-i]=1.
  - Else: `Rw` = `S`[31:0] and `Qw`[31-i]=0.
  - The compare is 33-bit. The bit shifted out of `Rw`[31] must not be dropped, or divisors ≥ 2^31 give wrong results.
  - `i` increments each iteration. When `i`=31, `i` wraps to 0, state goes to DONE, and the final `Qw`/`Rw` are copied to `Q`/`R` on the same edge.
- `start` in RUN is ignored: no queuing, and the latched operands do not change.
- `Q`/`R` change only on completion, reset, or the divide-by-zero shortcut. They stay stable across RUN.
- Arithmetic is unsigned throughout. Invariants: `N` = `Q`·`D` + `R`, and `R` < `D` whenever `D` ≠ 0.

## Timing
- Edge E0 accepts `start`.
- Iterations run on E1..E32 (`i`=0..31).
- `done`=1 and `Q`/`R` are valid in the cycle after E32, so latency is 32 clocks from acceptance.
- Divide-by-zero: `done` is asserted in the cycle after E0, a latency of 1.
- `ready`=0 exactly during RUN.
- `done` is a single-cycle pulse.
- Back-to-back: `start` held high in DONE is accepted on that edge. Throughput is one division per 33 cycles.
- Reset mid-RUN aborts immediately and asynchronously. No `done` is produced, and `Q`/`R` read 0.

## Test plan
- `N`=100, `D`=7 -> `done` 32 clocks after accept; `Q`=14, `R`=2, `div_by_zero`=0; `ready` low for exactly 32 cycles.
- `N`=5, `D`=9 -> `Q`=0, `R`=5. Then `N`=32'hFFFFFFFF, `D`=1 -> `Q`=32'hFFFFFFFF, `R`=0.
- `N`=32'hFFFFFFFF, `D`=32'h80000000 -> `Q`=1, `R`=32'h7FFFFFFF. Also `N`=32'hFFFFFFFE, `D`=32'hFFFFFFFF -> `Q`=0, `R`=32'hFFFFFFFE. These check the 33-bit compare.
- `N`=1234, `D`=0 -> `done` the cycle after accept; `Q`=32'hFFFFFFFF, `R`=1234, `div_by_zero`=1. The next valid division clears `div_by_zero`.
- `start` with `N`=1000, `D`=3, then `start` pulsed with `N`=9, `D`=9 at iteration 10 -> second request ignored; result `Q`=333, `R`=1.
- Hold `start` high through DONE (`N`=7, `D`=2), then `N`=50, `D`=5: second division accepted on the DONE edge -> results `Q`=3/`R`=1, then `Q`=10/`R`=0, with two `done` pulses 33 cycles apart.
- Assert `rst_n`=0 at iteration 16 -> outputs immediately 0, `ready`=1, no `done`. Then `N`=9, `D`=4 -> `Q`=2, `R`=1.

Source files
------------

// File: rtl/unsigned_divider_ctrl.sv
// Sequential controller for a 32-bit unsigned restoring divider: one quotient
// bit per clock, plus operand capture, start/done handshake and a divide-by-zero shortcut.
module unsigned_divider_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] N,
    input  logic [WIDTH-1:0] D,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             div_by_zero
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [4:0]       i_q, i_d;
    logic [WIDTH-1:0] n_q, n_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [WIDTH-1:0] rw_q, rw_d;
    logic [WIDTH-1:0] qw_q, qw_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;
    logic             ready_q, ready_d;

    logic [4:0]       bit_idx_s;
    logic [WIDTH:0]   shift_s;
    logic [WIDTH:0]   diff_s;
    logic             fits_s;

    // Shift-in and trial subtract are kept 33 bits wide so a remainder bit
    // shifted out of Rw[31] still takes part in the compare.
    assign bit_idx_s = 5'd31 - i_q;
    assign shift_s   = {rw_q, n_q[bit_idx_s]};
    assign diff_s    = shift_s - {1'b0, d_q};
    assign fits_s    = (shift_s >= {1'b0, d_q});

    // Next-state, datapath and output-register logic.
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        n_d     = n_q;
        d_d     = d_q;
        rw_d    = rw_q;
        qw_d    = qw_q;
        q_d     = q_q;
        r_d     = r_q;
        done_d  = 1'b0;
        dbz_d   = dbz_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    n_d   = N;
                    d_d   = D;
                    rw_d  = 32'd0;
                    qw_d  = 32'd0;
                    i_d   = 5'd0;
                    dbz_d = 1'b0;
                    if (D == 32'd0) begin
                        state_d = ST_DONE;
                        q_d     = 32'hFFFF_FFFF;
                        r_d     = N;
                        dbz_d   = 1'b1;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (fits_s) begin
                    rw_d            = diff_s[WIDTH-1:0];
                    qw_d[bit_idx_s] = 1'b1;
                end else begin
                    rw_d            = shift_s[WIDTH-1:0];
                    qw_d[bit_idx_s] = 1'b0;
                end
                if (i_q == 5'd31) begin
                    i_d     = 5'd0;
                    state_d = ST_DONE;
                    q_d     = qw_d;
                    r_d     = rw_d;
                    done_d  = 1'b1;
                end else begin
                    i_d = i_q + 5'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        ready_d = (state_d != ST_RUN);
    end

    // State and output registers; reset aborts any division in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            i_q     <= 5'd0;
            n_q     <= 32'd0;
            d_q     <= 32'd0;
            rw_q    <= 32'd0;
            qw_q    <= 32'd0;
            q_q     <= 32'd0;
            r_q     <= 32'd0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            n_q     <= n_d;
            d_q     <= d_d;
            rw_q    <= rw_d;
            qw_q    <= qw_d;
            q_q     <= q_d;
            r_q     <= r_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
            ready_q <= ready_d;
        end
    end

    assign ready       = ready_q;
    assign done        = done_q;
    assign Q           = q_q;
    assign R           = r_q;
    assign div_by_zero = dbz_q;

endmodule
